// File: rtl/aes_pkg.sv
// Shared AES definitions for the round sequencer.
//   AES_NR_128   : number of rounds for AES-128
//   AES_RK_IDX_W : width of the round-key index
//   AES_ROW_W    : width of one state row in the datapath
//   AES_LAT_W    : width of the per-round latency counter
//   aes_state_e  : controller state encoding
package aes_pkg;

  localparam int AES_NR_128   = 10;
  localparam int AES_RK_IDX_W = 4;
  localparam int AES_ROW_W    = 32;
  localparam int AES_LAT_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } aes_state_e;

endpackage

// File: rtl/aes_round_counter.sv
// Round and intra-round latency counters for the AES round sequencer.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   clear        : force both counters to 0
//   load_first   : initial round captured; round_cnt <= 1, lat_cnt <= 0
//   run          : a round (middle or final) is executing
//   stall        : round key not valid; blocks the capture cycle
//   round_cnt    : current round index 0..NR
//   lat_cnt      : cycle within the current round 0..ROUND_LAT-1
//   last_lat     : lat_cnt is on the capture cycle
//   last_round   : round_cnt is the last middle round (NR-1)
module aes_round_counter
  import aes_pkg::*;
#(
  parameter int NR        = AES_NR_128,
  parameter int ROUND_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    load_first,
  input  logic                    run,
  input  logic                    stall,
  output logic [AES_RK_IDX_W-1:0] round_cnt,
  output logic [AES_LAT_W-1:0]    lat_cnt,
  output logic                    last_lat,
  output logic                    last_round
);

  localparam logic [AES_LAT_W-1:0]    LAT_LAST = AES_LAT_W'(ROUND_LAT - 1);
  localparam logic [AES_RK_IDX_W-1:0] RND_MAX  = AES_RK_IDX_W'(NR);
  localparam logic [AES_RK_IDX_W-1:0] RND_LAST = AES_RK_IDX_W'(NR - 1);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      round_cnt <= '0;
      lat_cnt   <= '0;
    end else if (load_first) begin
      round_cnt <= AES_RK_IDX_W'(1);
      lat_cnt   <= '0;
    end else if (run) begin
      if (!last_lat) begin
        // Non-capture cycles advance regardless of key availability.
        lat_cnt <= lat_cnt + AES_LAT_W'(1);
      end else if (!stall) begin
        lat_cnt <= '0;
        // Saturate at NR so the final capture leaves the index at NR.
        if (round_cnt != RND_MAX) begin
          round_cnt <= round_cnt + AES_RK_IDX_W'(1);
        end
      end
    end
  end

  assign last_lat   = (lat_cnt == LAT_LAST);
  assign last_round = (round_cnt == RND_LAST);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer for a shared round datapath.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for a plaintext block, in_ready high
//   ST_INIT  | initial AddRoundKey with round key 0, plaintext selected
//   ST_ROUND | middle rounds 1..NR-1, full SubBytes/ShiftRows/MixColumns/ARK
//   ST_FINAL | last round NR, MixColumns bypassed
//   ST_DONE  | ciphertext held in the state rows, out_valid high
//
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   in_valid      : plaintext rows valid        in_ready  : block can be accepted
//   rk_req        : round key requested         rk_round  : requested key index
//   rk_valid      : requested key stable
//   dp_load_in    : state mux selects plaintext dp_state_en : state rows capture
//   dp_mix_bypass : MixColumns bypassed         dp_ark_only : AddRoundKey only
//   out_valid     : ciphertext valid            out_ready : consumer takes it
//   busy          : block in flight
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR        = AES_NR_128,
  parameter int ROUND_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    rk_req,
  output logic [AES_RK_IDX_W-1:0] rk_round,
  input  logic                    rk_valid,
  output logic                    dp_load_in,
  output logic                    dp_state_en,
  output logic                    dp_mix_bypass,
  output logic                    dp_ark_only,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  aes_state_e                state;
  aes_state_e                state_next;
  logic [AES_RK_IDX_W-1:0]   round_cnt;
  logic [AES_LAT_W-1:0]      lat_cnt;
  logic                      last_lat;
  logic                      last_round;

  aes_round_counter #(
    .NR        (NR),
    .ROUND_LAT (ROUND_LAT)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state == ST_IDLE),
    .load_first (state == ST_INIT && rk_valid),
    .run        (state == ST_ROUND || state == ST_FINAL),
    .stall      (!rk_valid),
    .round_cnt  (round_cnt),
    .lat_cnt    (lat_cnt),
    .last_lat   (last_lat),
    .last_round (last_round)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    in_ready      = 1'b0;
    rk_req        = 1'b0;
    rk_round      = '0;
    dp_load_in    = 1'b0;
    dp_state_en   = 1'b0;
    dp_mix_bypass = 1'b0;
    dp_ark_only   = 1'b0;
    out_valid     = 1'b0;
    busy          = 1'b0;

    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = ST_INIT;
        end
      end

      ST_INIT: begin
        rk_req      = 1'b1;
        dp_load_in  = 1'b1;
        dp_ark_only = 1'b1;
        busy        = 1'b1;
        if (rk_valid) begin
          dp_state_en = 1'b1;
          state_next  = (NR == 1) ? ST_FINAL : ST_ROUND;
        end
      end

      ST_ROUND: begin
        rk_req   = 1'b1;
        rk_round = round_cnt;
        busy     = 1'b1;
        if (last_lat && rk_valid) begin
          dp_state_en = 1'b1;
          if (last_round) begin
            state_next = ST_FINAL;
          end
        end
      end

      ST_FINAL: begin
        rk_req        = 1'b1;
        rk_round      = AES_RK_IDX_W'(NR);
        dp_mix_bypass = 1'b1;
        busy          = 1'b1;
        if (last_lat && rk_valid) begin
          dp_state_en = 1'b1;
          state_next  = ST_DONE;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        // Lets a new block enter in the same cycle the ciphertext is taken.
        in_ready  = out_ready;
        if (out_ready) begin
          state_next = in_valid ? ST_INIT : ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
